lcd_bus_monitor: RTL and testbench

Receive-side monitor for the `lcdBus` panel interface. It attaches to the bus through the `debug` modport and samples the panel signals in the system clock domain. It reconstructs frames and lines, checks line and frame geometry against the configured panel size, and streams captured pixels out through a small FIFO with a valid/ready handshake. It serves as on-FPGA loopback check of the display controller and as bench scoreboard input.

---
 rtl/lcd_bus_monitor_if.sv | 19 +
 rtl/lcd_bus_monitor.sv | 184 ++++++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_monitor_if.sv
// lcdBus panel interface: pixel data plus panel timing strobes.
// The debug modport observes every signal without driving any.
interface lcdBus;
    logic [23:0] rgb;
    logic        d_clk;
    logic        disp_en;
    logic        hsync;
    logic        vsync;
    logic        d_en;

    modport debug (
        input rgb,
        input d_clk,
        input disp_en,
        input hsync,
        input vsync,
        input d_en
    );
endinterface

// File: rtl/lcd_bus_monitor.sv
// Receive-side lcdBus monitor: frame/line reconstruction, geometry checks,
// and a valid/ready pixel FIFO fed from the synchronized panel signals.
module lcd_bus_monitor #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    lcdBus.debug        lcd,
    input  logic        cap_en,
    input  logic        clr_status,
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic        overflow,
    output logic [11:0] last_line_len,
    output logic [11:0] last_frame_lines
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [11:0] H_LEN   = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LEN   = 12'(V_ACTIVE);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        FRAME
    } state_t;

    state_t state, state_nx;

    logic [28:0] bus_s1, bus_s2;
    logic        dclk_s3;
    logic [23:0] rgb_s;
    logic        dclk_s, disp_s, hs_s, vs_s, den_s;

    logic        prev_den, prev_vs;
    logic [11:0] px_cnt, line_cnt;
    logic [11:0] px_inc, line_nx;

    logic ev, run, vs_fall, frame_ev;
    logic wr_req, line_end, frame_chk;
    logic wr_sof, wr_eol;
    logic line_set, frame_set, ovf_set;

    logic [25:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [25:0] head;
    logic        empty, full, push, pop;

    assign {rgb_s, dclk_s, disp_s, hs_s, vs_s, den_s} = bus_s2;

    // hsync is synchronized with the rest of the bus but never drives capture
    assign ev       = dclk_s & ~dclk_s3 & (hs_s | ~hs_s);
    assign run      = cap_en & disp_s;
    assign vs_fall  = ev & prev_vs & ~vs_s;
    assign frame_ev = (state == FRAME) & run & ev;
    assign wr_req   = frame_ev & den_s;
    assign line_end = frame_ev & ~den_s & prev_den;
    assign frame_chk = frame_ev & vs_fall;

    assign px_inc  = (px_cnt == CNT_MAX) ? px_cnt : px_cnt + 12'd1;
    assign line_nx = (line_end && line_cnt != CNT_MAX)
                   ? line_cnt + 12'd1 : line_cnt;

    assign wr_sof = (line_cnt == 12'd0) && (px_cnt == 12'd0);
    assign wr_eol = (px_cnt == H_LAST);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign pop   = ~empty & pix_ready;
    assign push  = wr_req & (~full | pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign pix_valid = ~empty;
    assign pix_data  = empty ? 24'd0 : head[23:0];
    assign pix_sof   = ~empty & head[25];
    assign pix_eol   = ~empty & head[24];

    assign line_set  = line_end & (px_cnt != H_LEN);
    assign frame_set = frame_chk & (line_nx != V_LEN);
    assign ovf_set   = wr_req & full & ~pop;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (run) state_nx = SEEK;
            SEEK:    if (vs_fall) state_nx = FRAME;
            FRAME:   state_nx = FRAME;
            default: state_nx = IDLE;
        endcase
        if (!run) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_s1   <= '0;
            bus_s2   <= '0;
            dclk_s3  <= 1'b0;
            prev_den <= 1'b0;
            prev_vs  <= 1'b0;
        end else begin
            bus_s1 <= {lcd.rgb, lcd.d_clk, lcd.disp_en,
                       lcd.hsync, lcd.vsync, lcd.d_en};
            bus_s2  <= bus_s1;
            dclk_s3 <= dclk_s;
            if (ev) begin
                prev_den <= den_s;
                prev_vs  <= vs_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_cnt           <= '0;
            line_cnt         <= '0;
            last_line_len    <= '0;
            last_frame_lines <= '0;
            frame_done       <= 1'b0;
        end else begin
            frame_done <= frame_chk;
            if (state == IDLE || !run) begin
                px_cnt   <= '0;
                line_cnt <= '0;
            end else if (frame_ev) begin
                if (den_s) px_cnt <= px_inc;
                else if (line_end) px_cnt <= '0;
                if (line_end) last_line_len <= px_cnt;
                // a new frame always restarts at line 0, pixel 0
                if (frame_chk) begin
                    last_frame_lines <= line_nx;
                    line_cnt         <= '0;
                    px_cnt           <= '0;
                end else begin
                    line_cnt <= line_nx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            line_err  <= line_set  | (line_err  & ~clr_status);
            frame_err <= frame_set | (frame_err & ~clr_status);
            overflow  <= ovf_set   | (overflow  & ~clr_status);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {wr_sof, wr_eol, rgb_s};
    end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor on a reduced 8x4 panel geometry.
// The bench paces the panel bus itself at d_clk = clk/4.
module tb_lcd_bus_monitor;

    localparam int H = 8;
    localparam int V = 4;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_en = 1'b0;
    logic        clr_status = 1'b0;
    logic        pix_ready = 1'b1;
    logic [23:0] pix_data;
    logic        pix_sof, pix_eol, pix_valid;
    logic        frame_done, line_err, frame_err, overflow;
    logic [11:0] last_line_len, last_frame_lines;

    lcdBus bus();

    lcd_bus_monitor #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lcd(bus),
        .cap_en(cap_en),
        .clr_status(clr_status),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .pix_eol(pix_eol),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .frame_done(frame_done),
        .line_err(line_err),
        .frame_err(frame_err),
        .overflow(overflow),
        .last_line_len(last_line_len),
        .last_frame_lines(last_frame_lines)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    logic [25:0] rx_q[$];

    // record every accepted pixel and every frame_done pulse
    always @(negedge clk) begin
        #2;
        if (!rst && pix_valid && pix_ready)
            rx_q.push_back({pix_sof, pix_eol, pix_data});
        if (!rst && frame_done) fd_cnt++;
    end

    task automatic drive_px(input logic den, input logic vs,
                            input logic [23:0] rgb);
        bus.d_en = den;
        bus.vsync = vs;
        bus.rgb = rgb;
        bus.d_clk = 1'b0;
        repeat (2) @(negedge clk);
        bus.d_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_px(1'b0, 1'b1, 24'd0);
    endtask

    task automatic send_vsync();
        drive_px(1'b0, 1'b0, 24'd0);
        drive_px(1'b0, 1'b1, 24'd0);
    endtask

    task automatic send_line(input int n, input int ln, input int tag);
        for (int p = 0; p < n; p++)
            drive_px(1'b1, 1'b1, {tag[7:0], ln[7:0], p[7:0]});
        idle(2);
    endtask

    task automatic test_reset();
        bus.rgb = 24'd0;
        bus.d_clk = 1'b0;
        bus.disp_en = 1'b1;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.d_en = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", pix_valid);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({pix_sof, pix_eol, frame_done, line_err, frame_err, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000000",
                     {pix_sof, pix_eol, frame_done, line_err, frame_err, overflow});
        end
        n_chk++;
        if ({pix_data, last_line_len, last_frame_lines} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%0d/%0d want 0/0/0",
                     pix_data, last_line_len, last_frame_lines);
        end
    endtask

    task automatic test_ref_frame();
        logic [25:0] exp;
        int bad;
        cap_en = 1'b1;
        rx_q.delete();
        fd_cnt = 0;
        idle(3);
        send_vsync();
        for (int l = 0; l < V; l++) send_line(H, l, 1);
        send_vsync();
        idle(2);
        n_chk++;
        if (rx_q.size() != H * V) begin
            n_fail++;
            $display("FAIL ref_count got %0d want %0d", rx_q.size(), H * V);
        end
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < H * V; i++) begin
            exp = {i == 0, (i % H) == H - 1, 8'h01, 8'(i / H), 8'(i % H)};
            if (rx_q[i] !== exp) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ref_pixels got %0d bad entries want 0", bad);
        end
        n_chk++;
        if (fd_cnt != 1) begin
            n_fail++;
            $display("FAIL ref_frame_done got %0d want 1", fd_cnt);
        end
        n_chk++;
        if (last_line_len !== 12'd8 || last_frame_lines !== 12'd4) begin
            n_fail++;
            $display("FAIL ref_geometry got %0d/%0d want 8/4",
                     last_line_len, last_frame_lines);
        end
        n_chk++;
        if ({line_err, frame_err, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL ref_errors got %b want 000",
                     {line_err, frame_err, overflow});
        end
    endtask

    task automatic test_short_line();
        int eols;
        rx_q.delete();
        fd_cnt = 0;
        send_line(H, 0, 2);
        send_line(H, 1, 2);
        send_line(H - 1, 2, 2);
        n_chk++;
        if (line_err !== 1'b1 || last_line_len !== 12'd7) begin
            n_fail++;
            $display("FAIL short_line got err=%b len=%0d want err=1 len=7",
                     line_err, last_line_len);
        end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        @(negedge clk);
        n_chk++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL short_clear got %b want 0", line_err);
        end
        send_line(H, 3, 2);
        send_vsync();
        idle(1);
        n_chk++;
        if (frame_err !== 1'b0 || last_frame_lines !== 12'd4 || fd_cnt != 1) begin
            n_fail++;
            $display("FAIL short_frame got ferr=%b lines=%0d fd=%0d want 0/4/1",
                     frame_err, last_frame_lines, fd_cnt);
        end
        eols = 0;
        foreach (rx_q[i]) if (rx_q[i][24]) eols++;
        n_chk++;
        if (rx_q.size() != 31 || eols != 3) begin
            n_fail++;
            $display("FAIL short_stream got n=%0d eol=%0d want 31/3",
                     rx_q.size(), eols);
        end
    endtask

    task automatic test_long_frame();
        fd_cnt = 0;
        for (int l = 0; l < V + 1; l++) send_line(H, l, 3);
        send_vsync();
        idle(1);
        n_chk++;
        if (frame_err !== 1'b1 || last_frame_lines !== 12'd5) begin
            n_fail++;
            $display("FAIL long_frame got err=%b lines=%0d want 1/5",
                     frame_err, last_frame_lines);
        end
        n_chk++;
        if (fd_cnt != 1 || line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL long_done got fd=%0d lerr=%b want 1/0",
                     fd_cnt, line_err);
        end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        @(negedge clk);
        n_chk++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL long_clear got %b want 0", frame_err);
        end
    endtask

    task automatic test_overflow();
        logic [25:0] exp;
        int bad;
        rx_q.delete();
        pix_ready = 1'b0;
        for (int l = 0; l < 3; l++) send_line(H, l, 4);
        repeat (3) @(negedge clk);
        n_chk++;
        if (overflow !== 1'b1 || pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag got ovf=%b valid=%b want 1/1",
                     overflow, pix_valid);
        end
        n_chk++;
        if ({pix_sof, pix_eol, pix_data} !== {2'b10, 24'h040000}) begin
            n_fail++;
            $display("FAIL ovf_head got %b%b %h want 10 040000",
                     pix_sof, pix_eol, pix_data);
        end
        pix_ready = 1'b1;
        repeat (24) @(negedge clk);
        n_chk++;
        if (rx_q.size() != D) begin
            n_fail++;
            $display("FAIL ovf_drain got %0d want %0d", rx_q.size(), D);
        end
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < D; i++) begin
            exp = {i == 0, (i % H) == H - 1, 8'h04, 8'(i / H), 8'(i % H)};
            if (rx_q[i] !== exp) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ovf_order got %0d bad entries want 0", bad);
        end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        @(negedge clk);
        n_chk++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", overflow);
        end
    endtask

    task automatic test_abort_reset();
        rx_q.delete();
        fd_cnt = 0;
        for (int p = 0; p < 4; p++) drive_px(1'b1, 1'b1, {8'h05, 8'h03, 8'(p)});
        repeat (3) @(negedge clk);
        cap_en = 1'b0;
        idle(1);
        send_vsync();
        idle(1);
        n_chk++;
        if (fd_cnt != 0 || rx_q.size() != 4) begin
            n_fail++;
            $display("FAIL abort_idle got fd=%0d n=%0d want 0/4",
                     fd_cnt, rx_q.size());
        end
        cap_en = 1'b1;
        for (int p = 0; p < 3; p++) drive_px(1'b1, 1'b1, {8'h05, 8'h09, 8'(p)});
        idle(1);
        n_chk++;
        if (rx_q.size() != 4) begin
            n_fail++;
            $display("FAIL abort_seek got %0d want 4", rx_q.size());
        end
        send_vsync();
        pix_ready = 1'b0;
        for (int p = 0; p < 3; p++) drive_px(1'b1, 1'b1, {8'h06, 8'h00, 8'(p)});
        repeat (3) @(negedge clk);
        n_chk++;
        if (pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst_valid got %b want 1", pix_valid);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({pix_valid, pix_sof, pix_eol, frame_done, line_err, frame_err, overflow} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_flags got %b want 0000000",
                     {pix_valid, pix_sof, pix_eol, frame_done, line_err, frame_err, overflow});
        end
        n_chk++;
        if ({pix_data, last_line_len, last_frame_lines} !== 48'd0) begin
            n_fail++;
            $display("FAIL rst_data got %h/%0d/%0d want 0/0/0",
                     pix_data, last_line_len, last_frame_lines);
        end
        @(negedge clk);
        rst = 1'b0;
        pix_ready = 1'b1;
        rx_q.delete();
        for (int p = 0; p < 3; p++) drive_px(1'b1, 1'b1, {8'h06, 8'h00, 8'(p + 3)});
        idle(1);
        n_chk++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_seek got %0d want 0", rx_q.size());
        end
        send_vsync();
        send_line(H, 0, 7);
        n_chk++;
        if (rx_q.size() != H) begin
            n_fail++;
            $display("FAIL restart_count got %0d want %0d", rx_q.size(), H);
        end else begin
            n_chk++;
            if (rx_q[0] !== {2'b10, 24'h070000} || rx_q[H-1] !== {2'b01, 24'h070007}) begin
                n_fail++;
                $display("FAIL restart_pixels got %h/%h want 2070000/1070007",
                         rx_q[0], rx_q[H-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ref_frame();
        test_short_line();
        test_long_frame();
        test_overflow();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
